seg7_display_ctrl: RTL and testbench

- I/O slave on the store path, downstream of the memory/IO address decoder.
- Consumes the digit chip select (DigCtrl, asserted for 0x80/0x82 with ioWrite) and the 16-bit IO write data.
- Holds a 32-bit display value as eight hex nibbles.
- Time-multiplexes the value onto an 8-digit common-anode seven-segment tube.

---
 rtl/seg7_display_ctrl.sv | 83 ++++++++
 tb/tb_seg7_display_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// Write-only 32-bit hex display register, time-multiplexed onto an
// 8-digit common-anode seven-segment tube (active-low segments and anodes).
module seg7_display_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dig_cs,
    input  logic        dig_write,
    input  logic [1:0]  dig_addr,
    input  logic [15:0] dig_wdata,
    output logic [7:0]  seg_out,
    output logic [7:0]  seg_en
);

    logic [31:0]      disp_reg;
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       scan_idx;
    logic [3:0]       cur_nib;
    logic             scan_wrap;

    // Halfword address bit 0 carries no meaning for this slave.
    logic unused_addr_bit;
    assign unused_addr_bit = dig_addr[0];

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    always_comb begin
        cur_nib   = disp_reg[4*scan_idx +: 4];
        scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_reg <= '0;
            scan_cnt <= '0;
            scan_idx <= '0;
            seg_en   <= '1;
            seg_out  <= '1;
        end else begin
            if (dig_cs && dig_write) begin
                if (dig_addr[1])
                    disp_reg[31:16] <= dig_wdata;
                else
                    disp_reg[15:0]  <= dig_wdata;
            end

            if (scan_wrap) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            // Outputs sample the pre-edge register, so a write is never forwarded.
            seg_en  <= ~(8'b1 << scan_idx);
            seg_out <= {1'b1, hex7(cur_nib)};
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed self-checking bench for seg7_display_ctrl with a 4-cycle scan divider.
module tb_seg7_display_ctrl;

    localparam int SCAN_DIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dig_cs = 1'b0;
    logic        dig_write = 1'b0;
    logic [1:0]  dig_addr = '0;
    logic [15:0] dig_wdata = '0;
    logic [7:0]  seg_out;
    logic [7:0]  seg_en;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] en_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    seg7_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .dig_cs    (dig_cs),
        .dig_write (dig_write),
        .dig_addr  (dig_addr),
        .dig_wdata (dig_wdata),
        .seg_out   (seg_out),
        .seg_en    (seg_en)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_word(input logic cs, input logic we, input logic [1:0] addr,
                              input logic [15:0] data);
        dig_cs    = cs;
        dig_write = we;
        dig_addr  = addr;
        dig_wdata = data;
        tick();
        dig_cs    = 1'b0;
        dig_write = 1'b0;
    endtask

    // codes packs digit 7's expected seg_out in the top byte, digit 0 in the bottom.
    task automatic check_edges(input string name, input int first, input int last,
                               input logic [63:0] codes);
        int d;
        for (int e = first; e <= last; e++) begin
            tick();
            d = (e - 1) / SCAN_DIV;
            check($sformatf("%s en e%0d", name, e), seg_en, en_tbl[d]);
            check($sformatf("%s seg e%0d", name, e), seg_out, codes[8*d +: 8]);
        end
    endtask

    initial begin
        // Reset held for three edges
        skip(3);
        check("reset en", seg_en, 8'hFF);
        check("reset seg", seg_out, 8'hFF);
        reset = 1'b0;

        // Blank register: full frame walk of anodes, every digit shows 0
        check_edges("zero", 1, 32, {8{8'hC0}});

        // 0x7654_3210 via low then high halfword
        write_word(1'b1, 1'b1, 2'b00, 16'h3210);
        write_word(1'b1, 1'b1, 2'b10, 16'h7654);
        skip(30);
        check_edges("digits", 1, 32,
                    {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0});

        // 0xFEDC_BA98 using odd addresses (bit 0 ignored)
        write_word(1'b1, 1'b1, 2'b01, 16'hBA98);
        write_word(1'b1, 1'b1, 2'b11, 16'hFEDC);
        skip(30);
        check_edges("letters", 1, 32,
                    {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80});

        // Half-qualified strobes must not write
        write_word(1'b1, 1'b0, 2'b00, 16'hFFFF);
        write_word(1'b0, 1'b1, 2'b10, 16'hFFFF);
        skip(30);
        check_edges("nowrite", 1, 32,
                    {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80});

        // Restore 0x7654_3210, then write digit 0 while it is lit
        write_word(1'b1, 1'b1, 2'b00, 16'h3210);
        write_word(1'b1, 1'b1, 2'b10, 16'h7654);
        skip(30);
        tick();
        check("live pre en", seg_en, 8'hFE);
        check("live pre seg", seg_out, 8'hC0);
        write_word(1'b1, 1'b1, 2'b00, 16'h0005);
        check("live wedge seg", seg_out, 8'hC0);
        tick();
        check("live after seg", seg_out, 8'h92);
        check_edges("live", 4, 32,
                    {8'hF8, 8'h82, 8'h92, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'h92});

        // Reset mid-digit-5 with a concurrent write
        skip(22);
        check("mid en", seg_en, 8'hDF);
        check("mid seg", seg_out, 8'h92);
        reset = 1'b1;
        write_word(1'b1, 1'b1, 2'b10, 16'hFFFF);
        check("rst mid en", seg_en, 8'hFF);
        check("rst mid seg", seg_out, 8'hFF);
        reset = 1'b0;
        check_edges("restart", 1, 32, {8{8'hC0}});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
